// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants, control word type and op decode for the ID-stage controller
package ctrl_pkg;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_BLOCK  = 2'b11;

  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       b;
    logic       s;
  } ctrl_word_t;

  function automatic logic [3:0] op_to_exe(input logic [3:0] op);
    case (op)
      OP_AND, OP_TST: op_to_exe = EXE_AND;
      OP_EOR:         op_to_exe = EXE_EOR;
      OP_SUB, OP_CMP: op_to_exe = EXE_SUB;
      OP_ADD:         op_to_exe = EXE_ADD;
      OP_ADC:         op_to_exe = EXE_ADC;
      OP_SBC:         op_to_exe = EXE_SBC;
      OP_ORR:         op_to_exe = EXE_ORR;
      OP_MOV:         op_to_exe = EXE_MOV;
      OP_MVN:         op_to_exe = EXE_MVN;
      default:        op_to_exe = EXE_NONE;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_ADC, OP_SBC,
      OP_TST, OP_CMP, OP_ORR, OP_MOV, OP_MVN: op_is_legal = 1'b1;
      default:                                op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder with found and single-bit flags
module prio_enc_lsb #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]  mask_i,
  output logic [REG_IDX_W-1:0] idx_o,
  output logic                 found_o,
  output logic                 last_o
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = REG_IDX_W'(i);
    end
  end

  assign found_o = |mask_i;
  assign last_o  = found_o && ((mask_i & (mask_i - NUM_REGS'(1))) == '0);

endmodule

// File: rtl/exe_ctrl_seq.sv
// rtl/exe_ctrl_seq.sv - registered ID-stage decode controller with block-transfer sequencing
// Optional undefined-op trap output illegal_op under `CTRL_ILLEGAL_TRAP_EN.
module exe_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int  EXE_CMD_W = 4,
  parameter int  NUM_REGS  = 16,
  localparam int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [3:0]           op_code,
  input  logic                 s,
  input  logic [NUM_REGS-1:0]  reg_list,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 b,
  output logic                 s_out,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic [REG_IDX_W-1:0] xfer_reg,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                 illegal_op,
`endif
  output logic                 xfer_last
);

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  burst_s_q, burst_s_d;
  logic                  out_valid_q, out_valid_d;
  ctrl_word_t            word_q, word_d;
  logic [REG_IDX_W-1:0]  xfer_reg_q, xfer_reg_d;
  logic                  xfer_last_q, xfer_last_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  illegal_q, illegal_d;
`endif

  logic [REG_IDX_W-1:0]  enc_idx;
  logic                  enc_found, enc_last;
  logic                  advance, accept;

  prio_enc_lsb #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_enc (
    .mask_i  (pending_q),
    .idx_o   (enc_idx),
    .found_o (enc_found),
    .last_o  (enc_last)
  );

  assign advance  = !out_valid_q || !stall;
  assign in_ready = !rst && (state_q == ST_IDLE) && advance && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    burst_s_d   = burst_s_q;
    out_valid_d = out_valid_q;
    word_d      = word_q;
    xfer_reg_d  = xfer_reg_q;
    xfer_last_d = xfer_last_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    // Flush and every advancing cycle start from an all-zero word so no stale enable survives.
    if (flush || advance) begin
      out_valid_d = 1'b0;
      word_d      = '0;
      xfer_reg_d  = '0;
      xfer_last_d = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d   = 1'b0;
`endif
    end
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else if (advance) begin
      if (state_q == ST_BURST) begin
        out_valid_d     = 1'b1;
        word_d.exe_cmd  = EXE_ADD;
        word_d.s        = burst_s_q;
        word_d.mem_r_en = burst_s_q;
        word_d.wb_en    = burst_s_q;
        word_d.mem_w_en = !burst_s_q;
        xfer_reg_d      = enc_idx;
        xfer_last_d     = enc_last;
        pending_d       = pending_q & ~(NUM_REGS'(1) << enc_idx);
        if (enc_last || !enc_found) state_d = ST_IDLE;
      end else if (accept) begin
        if (mode == MODE_BLOCK) begin
          pending_d = reg_list;
          burst_s_d = s;
          if (|reg_list) state_d = ST_BURST;
        end else begin
          out_valid_d    = 1'b1;
          xfer_last_d    = 1'b1;
          word_d.exe_cmd = op_to_exe(op_code);
          word_d.s       = s;
          case (mode)
            MODE_ARITH: begin
              word_d.wb_en = (op_code != OP_TST) && (op_code != OP_CMP);
`ifdef CTRL_ILLEGAL_TRAP_EN
              if (!op_is_legal(op_code)) begin
                word_d.wb_en = 1'b0;
                illegal_d    = 1'b1;
              end
`endif
            end
            MODE_MEM: begin
              word_d.mem_r_en = s;
              word_d.wb_en    = s;
              word_d.mem_w_en = !s;
            end
            default: word_d.b = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      burst_s_q   <= 1'b0;
      out_valid_q <= 1'b0;
      word_q      <= '0;
      xfer_reg_q  <= '0;
      xfer_last_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      burst_s_q   <= burst_s_d;
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      xfer_reg_q  <= xfer_reg_d;
      xfer_last_q <= xfer_last_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign wb_en     = word_q.wb_en;
  assign mem_r_en  = word_q.mem_r_en;
  assign mem_w_en  = word_q.mem_w_en;
  assign b         = word_q.b;
  assign s_out     = word_q.s;
  assign exe_cmd   = EXE_CMD_W'(word_q.exe_cmd);
  assign xfer_reg  = xfer_reg_q;
  assign xfer_last = xfer_last_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`endif

endmodule
